score_keeper: RTL

- Upstream of the game state FSM. Converts raw ball-out-of-bounds conditions into registered player/enemy scores. The FSM compares these scores against MAX_SCORE to end a match.
- Also sequences the serve: after every point the ball is held for a fixed number of frames, then released toward the side that conceded.
- Sits between the ball/collision logic and the game FSM. Scores also feed the score renderer.

---
 rtl/score_keeper.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: turns ball-out-of-bounds levels into registered player/enemy
// scores and sequences the serve hold after game reset and after each point.
// Optional build macro SCORE_BCD_EN adds registered two-digit BCD copies of
// both scores (requires MAX_SCORE <= 99).

package score_pkg;
    localparam int unsigned            M_SCORE_W = 4;
    localparam logic [M_SCORE_W-1:0]   MAX_SCORE = 4'd11;
endpackage

module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned CNT_W        = $clog2(SERVE_FRAMES + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 frame_tick_i,
    input  logic                 game_en_i,
    input  logic                 game_rst_i,
    input  logic                 p_miss_i,
    input  logic                 e_miss_i,
    output logic [M_SCORE_W-1:0] p_score_o,
    output logic [M_SCORE_W-1:0] e_score_o,
    output logic                 ball_hold_o,
    output logic                 serve_dir_o,
    output logic                 point_o
`ifdef SCORE_BCD_EN
    ,
    output logic [3:0]           p_bcd_tens_o,
    output logic [3:0]           p_bcd_ones_o,
    output logic [3:0]           e_bcd_tens_o,
    output logic [3:0]           e_bcd_ones_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_RALLY,
        ST_OVER
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;

    // cur = input registered once, prev = one cycle older; both reset high so
    // a miss level present out of reset never looks like a new edge.
    logic                 p_miss_cur, p_miss_prev;
    logic                 e_miss_cur, e_miss_prev;
    logic                 p_edge, e_edge;

    logic [M_SCORE_W-1:0] p_inc, e_inc;

    // Miss input registration for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_miss_cur  <= 1'b1;
            p_miss_prev <= 1'b1;
            e_miss_cur  <= 1'b1;
            e_miss_prev <= 1'b1;
        end else begin
            p_miss_cur  <= p_miss_i;
            p_miss_prev <= p_miss_cur;
            e_miss_cur  <= e_miss_i;
            e_miss_prev <= e_miss_cur;
        end
    end

    assign p_edge = p_miss_cur & ~p_miss_prev;
    assign e_edge = e_miss_cur & ~e_miss_prev;

    // Saturating next scores
    assign p_inc = (p_score_o == MAX_SCORE) ? p_score_o : p_score_o + M_SCORE_W'(1);
    assign e_inc = (e_score_o == MAX_SCORE) ? e_score_o : e_score_o + M_SCORE_W'(1);

`ifdef SCORE_BCD_EN
    logic [7:0] p_bcd, e_bcd;

    function automatic logic [7:0] bcd_next(input logic [7:0] bcd);
        if (bcd[3:0] == 4'd9) begin
            return {bcd[7:4] + 4'd1, 4'd0};
        end
        return {bcd[7:4], bcd[3:0] + 4'd1};
    endfunction

    assign p_bcd_tens_o = p_bcd[7:4];
    assign p_bcd_ones_o = p_bcd[3:0];
    assign e_bcd_tens_o = e_bcd[7:4];
    assign e_bcd_ones_o = e_bcd[3:0];
`endif

    // Game/serve FSM with registered scores, hold, serve direction and point pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            p_score_o   <= '0;
            e_score_o   <= '0;
            ball_hold_o <= 1'b1;
            serve_dir_o <= 1'b0;
            point_o     <= 1'b0;
`ifdef SCORE_BCD_EN
            p_bcd       <= '0;
            e_bcd       <= '0;
`endif
        end else begin
            point_o <= 1'b0;
            if (game_rst_i) begin
                state       <= ST_SERVE;
                cnt         <= '0;
                p_score_o   <= '0;
                e_score_o   <= '0;
                ball_hold_o <= 1'b1;
                serve_dir_o <= 1'b0;
`ifdef SCORE_BCD_EN
                p_bcd       <= '0;
                e_bcd       <= '0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        ball_hold_o <= 1'b1;
                    end

                    ST_SERVE: begin
                        if (!game_en_i) begin
                            state       <= ST_IDLE;
                            ball_hold_o <= 1'b1;
                        end else if (frame_tick_i) begin
                            if (cnt == CNT_LAST) begin
                                cnt         <= '0;
                                state       <= ST_RALLY;
                                ball_hold_o <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end

                    ST_RALLY: begin
                        if (!game_en_i) begin
                            state       <= ST_IDLE;
                            ball_hold_o <= 1'b1;
                        end else if (p_edge && e_edge) begin
                            state       <= ST_SERVE;
                            cnt         <= '0;
                            ball_hold_o <= 1'b1;
                        end else if (p_edge) begin
                            e_score_o   <= e_inc;
                            serve_dir_o <= 1'b0;
                            point_o     <= 1'b1;
                            cnt         <= '0;
                            ball_hold_o <= 1'b1;
                            state       <= (e_inc == MAX_SCORE) ? ST_OVER : ST_SERVE;
`ifdef SCORE_BCD_EN
                            if (e_score_o != MAX_SCORE) e_bcd <= bcd_next(e_bcd);
`endif
                        end else if (e_edge) begin
                            p_score_o   <= p_inc;
                            serve_dir_o <= 1'b1;
                            point_o     <= 1'b1;
                            cnt         <= '0;
                            ball_hold_o <= 1'b1;
                            state       <= (p_inc == MAX_SCORE) ? ST_OVER : ST_SERVE;
`ifdef SCORE_BCD_EN
                            if (p_score_o != MAX_SCORE) p_bcd <= bcd_next(p_bcd);
`endif
                        end
                    end

                    ST_OVER: begin
                        ball_hold_o <= 1'b1;
                    end

                    default: begin
                        state       <= ST_IDLE;
                        ball_hold_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
